// File: rtl/gpio_pad_bank_pkg.sv
// gpio_pad_bank_pkg
//   Shared defaults for the GPIO pad bank.
//   NB_PADS_DEF : default number of pads per bank
//   FILT_W_DEF  : default width of the glitch-filter length and counters
//   FILT_MIN    : smallest effective filter length (a programmed 0 acts as this)
package gpio_pad_bank_pkg;

    localparam int NB_PADS_DEF = 16;
    localparam int FILT_W_DEF  = 4;
    localparam int FILT_MIN    = 1;

endpackage

// File: rtl/gpio_pad_bank_pad_in_filter.sv
// pad_in_filter
//   Input conditioning for one pad: 2-flop synchroniser, programmable glitch
//   filter and registered rise/fall pulses.
//   Ports:
//     clk_in : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     raw    : pin value already gated by the input enable
//     len    : filter length; 0 behaves as 1
//     din    : filtered pin value
//     rise   : 1-cycle pulse when din goes 0->1
//     fall   : 1-cycle pulse when din goes 1->0
module pad_in_filter
    import gpio_pad_bank_pkg::*;
#(
    parameter int FILT_W = FILT_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              raw,
    input  logic [FILT_W-1:0] len,
    output logic              din,
    output logic              rise,
    output logic              fall
);

    logic              sync_p0;
    logic              sync_p1;
    logic              stable_p2;
    logic [FILT_W-1:0] cnt_p2;
    logic              rise_p2;
    logic              fall_p2;
    logic [FILT_W-1:0] thresh;
    logic              differ;
    logic              commit;

    function automatic logic [FILT_W-1:0] eff_len(input logic [FILT_W-1:0] l);
        eff_len = (l < FILT_W'(FILT_MIN)) ? FILT_W'(FILT_MIN) : l;
    endfunction

    // The >= compare fires before cnt can pass thresh, so cnt never wraps,
    // and a shortened len resolves a long pending count on the next cycle.
    assign thresh = eff_len(len) - FILT_W'(1);
    assign differ = (sync_p1 != stable_p2);
    assign commit = differ && (cnt_p2 >= thresh);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            stable_p2 <= 1'b0;
            cnt_p2    <= '0;
            rise_p2   <= 1'b0;
            fall_p2   <= 1'b0;
        end else begin
            // Stage p0/p1: metastability synchroniser
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            // Stage p2: filter state and edge pulses
            rise_p2 <= commit &  sync_p1;
            fall_p2 <= commit & ~sync_p1;
            if (!differ) begin
                cnt_p2 <= '0;
            end else if (commit) begin
                stable_p2 <= sync_p1;
                cnt_p2    <= '0;
            end else begin
                cnt_p2 <= cnt_p2 + FILT_W'(1);
            end
        end
    end

    assign din  = stable_p2;
    assign rise = rise_p2;
    assign fall = fall_p2;

endmodule

// File: rtl/gpio_pad_bank.sv
// gpio_pad_bank
//   Generated array of NB_PADS bidirectional pads between chip pins and the
//   pin mux, with per-pad open-drain output and filtered input.
//   Build option: define PAD_OUT_REG_EN to register dout/oe/od before the
//   drivers (one extra cycle of output latency).
//   Ports:
//     clk_in        : system clock, rising edge
//     rst_n         : asynchronous active-low reset; drivers off while low
//     PAD           : chip pins (inout)
//     pmux_pad_dout : output data
//     pmux_pad_oe   : output enable, 1 = drive
//     pmux_pad_od   : open-drain select, 1 = drive low only
//     pmux_pad_ie   : input enable, 1 = sample the pin
//     cfg_filt_len  : filter length shared by all pads, 0 acts as 1
//     pad_pmux_din  : synchronised, filtered pin value
//     pad_pmux_rise : 1-cycle pulse on filtered 0->1
//     pad_pmux_fall : 1-cycle pulse on filtered 1->0
module gpio_pad_bank
    import gpio_pad_bank_pkg::*;
#(
    parameter int NB_PADS = NB_PADS_DEF,
    parameter int FILT_W  = FILT_W_DEF
) (
    input  logic               clk_in,
    input  logic               rst_n,
    inout  wire  [NB_PADS-1:0] PAD,
    input  logic [NB_PADS-1:0] pmux_pad_dout,
    input  logic [NB_PADS-1:0] pmux_pad_oe,
    input  logic [NB_PADS-1:0] pmux_pad_od,
    input  logic [NB_PADS-1:0] pmux_pad_ie,
    input  logic [FILT_W-1:0]  cfg_filt_len,
    output logic [NB_PADS-1:0] pad_pmux_din,
    output logic [NB_PADS-1:0] pad_pmux_rise,
    output logic [NB_PADS-1:0] pad_pmux_fall
);

    logic [NB_PADS-1:0] dout_drv;
    logic [NB_PADS-1:0] oe_drv;
    logic [NB_PADS-1:0] od_drv;

`ifdef PAD_OUT_REG_EN
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            dout_drv <= '0;
            oe_drv   <= '0;
            od_drv   <= '0;
        end else begin
            // Stage p0: output controls registered ahead of the drivers
            dout_drv <= pmux_pad_dout;
            oe_drv   <= pmux_pad_oe;
            od_drv   <= pmux_pad_od;
        end
    end
`else
    assign dout_drv = pmux_pad_dout;
    assign oe_drv   = pmux_pad_oe;
    assign od_drv   = pmux_pad_od;
`endif

    genvar i;
    generate
        for (i = 0; i < NB_PADS; i++) begin : g_pad
            logic drive_en;
            logic raw;

            // Open drain only ever drives a 0, so the driven value is dout in
            // both modes; od just removes the drive when dout is 1.
            assign drive_en = rst_n & oe_drv[i] & ~(od_drv[i] & dout_drv[i]);
            assign PAD[i]   = drive_en ? dout_drv[i] : 1'bz;

            // Own drive is read back when ie=1; ie=0 reads as a filtered low.
            assign raw = PAD[i] & pmux_pad_ie[i];

            pad_in_filter #(
                .FILT_W (FILT_W)
            ) u_filt (
                .clk_in (clk_in),
                .rst_n  (rst_n),
                .raw    (raw),
                .len    (cfg_filt_len),
                .din    (pad_pmux_din[i]),
                .rise   (pad_pmux_rise[i]),
                .fall   (pad_pmux_fall[i])
            );
        end
    endgenerate

endmodule
